regfile_write_arbiter: RTL and testbench

- Shares the two write ports of the 8x16 dual-write-port register file among NREQ requesters (execution units, load return, etc.).
- Grants up to two writes per cycle in round-robin order.
- Never issues two same-address writes in one cycle. The register file's port-2-wins conflict rule is therefore never relied on, and same-address writes from different requesters are serialized.
- Sits directly in front of the register file; its registered outputs connect straight to the we1/we2, write_addr*/write_data* inputs.

---
 rtl/regfile_write_arbiter.sv | 121 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin write arbiter for a dual-write-port register file.
// Grants up to two requesters per cycle. The two grants never target the
// same register. A requester whose address matches slot A waits for a later
// cycle, and each cycle where that happens is counted in conflict_cnt.
// Outputs are registered so that they can drive the register file write ports directly.
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 16,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we1,
    output logic [AW-1:0]        write_addr1,
    output logic [DW-1:0]        write_data1,
    output logic                 we2,
    output logic [AW-1:0]        write_addr2,
    output logic [DW-1:0]        write_data2,
    output logic [15:0]          conflict_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW:0]   scan_sum;
    logic [PW-1:0] cur;
    logic          found_a;
    logic          found_b;
    logic          defer;
    logic [PW-1:0] a_idx;
    logic [PW-1:0] b_idx;
    logic [AW-1:0] a_addr;
    logic          grant_ok;
    logic          grant_a;
    logic          grant_b;

    // Index after i. It wraps from NREQ-1 to 0, so NREQ does not have to be a power of two.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        if (int'(i) == NREQ - 1) return '0;
        else                     return i + PW'(1);
    endfunction

    // Scan the requesters in round-robin order starting at ptr. Pick slot A
    // and slot B, and record any same-address deferral that happens before B is found.
    always_comb begin
        // NOTE: every variable gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        found_a  = 1'b0;
        found_b  = 1'b0;
        defer    = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        a_addr   = '0;
        scan_sum = '0;
        cur      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, ptr} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NREQ)) scan_sum = scan_sum - (PW+1)'(NREQ);
            cur = scan_sum[PW-1:0];
            if (req_valid[cur]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    a_idx   = cur;
                    a_addr  = req_addr[cur*AW +: AW];
                end else if (!found_b) begin
                    if (req_addr[cur*AW +: AW] != a_addr) begin
                        found_b = 1'b1;
                        b_idx   = cur;
                    end else begin
                        defer = 1'b1;
                    end
                end
            end
        end
    end

    // Grants are purely combinational. No grant is issued during reset or stall.
    always_comb begin
        grant_ok  = rst && !stall;
        grant_a   = grant_ok && found_a;
        grant_b   = grant_ok && found_b;
        req_ready = '0;
        if (grant_a) req_ready[a_idx] = 1'b1;
        if (grant_b) req_ready[b_idx] = 1'b1;
    end

    // Register the granted writes and advance the pointer and the conflict counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
        if (!rst) begin
            we1          <= 1'b0;
            we2          <= 1'b0;
            write_addr1  <= '0;
            write_data1  <= '0;
            write_addr2  <= '0;
            write_data2  <= '0;
            conflict_cnt <= '0;
            ptr          <= '0;
        end else begin
            we1 <= grant_a;
            we2 <= grant_b;
            if (grant_a) begin
                write_addr1 <= a_addr;
                write_data1 <= req_data[a_idx*DW +: DW];
            end
            if (grant_b) begin
                write_addr2 <= req_addr[b_idx*AW +: AW];
                write_data2 <= req_data[b_idx*DW +: DW];
            end
            if (grant_b)      ptr <= wrap_inc(b_idx);
            else if (grant_a) ptr <= wrap_inc(a_idx);
            if (grant_ok && defer && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter. It runs directed scenarios and
// then a randomized run that is checked against a list-based reference model.
module tb_regfile_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 16;
    localparam int AW   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                stall;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                we1, we2;
    logic [AW-1:0]       write_addr1, write_addr2;
    logic [DW-1:0]       write_data1, write_data2;
    logic [15:0]         conflict_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Register file contents as the DUT's write ports update them. Port 2 wins a same-address write.
    logic [DW-1:0] rf [8];

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .we1(we1), .write_addr1(write_addr1), .write_data1(write_data1),
        .we2(we2), .write_addr2(write_addr2), .write_data2(write_data2),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Register file mirror driven from the DUT's write ports.
    always @(posedge clk) begin
        if (we1) rf[write_addr1] <= write_data1;
        if (we2) rf[write_addr2] <= write_data2;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic set_all_distinct();
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'((i + 1) * 16'h1111));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; req_valid = 4'hF; set_all_distinct();
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want %b", req_ready, 4'b0000); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, we2, conflict_cnt} !== {1'b0, 1'b0, 16'h0}) begin n_bad++; $display("FAIL reset_outputs: got we1=%b we2=%b cnt=%h want 0 0 0000", we1, we2, conflict_cnt); end
        @(negedge clk); #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready_hold: got %b want %b", req_ready, 4'b0000); end
        @(negedge clk);
        rst = 1'b1; #1;
        n_cmp++; if (req_ready !== 4'b0011) begin n_bad++; $display("FAIL reset_release_ready: got %b want %b", req_ready, 4'b0011); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, we2, write_addr2, write_data2} !== {1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222})
            begin n_bad++; $display("FAIL reset_release_ports: got %b %0d %h %b %0d %h want 1 1 1111 1 2 2222", we1, write_addr1, write_data1, we2, write_addr2, write_data2); end
    endtask

    task automatic test_single_write();
        do_reset();
        req_valid = 4'b0001; set_req(0, 3'd1, 16'hAAAA);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want %b", req_ready, 4'b0001); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, we2} !== {1'b1, 3'd1, 16'hAAAA, 1'b0})
            begin n_bad++; $display("FAIL single_ports: got %b %0d %h %b want 1 1 aaaa 0", we1, write_addr1, write_data1, we2); end
        @(negedge clk); req_valid = '0;
        @(posedge clk); #1;
        n_cmp++; if ({we1, we2} !== 2'b00) begin n_bad++; $display("FAIL idle_ports: got %b%b want 00", we1, we2); end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_valid = 4'hF; set_all_distinct();
        #1;
        n_cmp++; if (req_ready !== 4'b0011) begin n_bad++; $display("FAIL rr_ready0: got %b want %b", req_ready, 4'b0011); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, we2, write_addr2, write_data2} !== {1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222})
            begin n_bad++; $display("FAIL rr_ports0: got %0d %h %0d %h want 1 1111 2 2222", write_addr1, write_data1, write_addr2, write_data2); end
        @(negedge clk); req_valid = 4'b1100; #1;
        n_cmp++; if (req_ready !== 4'b1100) begin n_bad++; $display("FAIL rr_ready1: got %b want %b", req_ready, 4'b1100); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, we2, write_addr2, write_data2} !== {1'b1, 3'd3, 16'h3333, 1'b1, 3'd4, 16'h4444})
            begin n_bad++; $display("FAIL rr_ports1: got %0d %h %0d %h want 3 3333 4 4444", write_addr1, write_data1, write_addr2, write_data2); end
        @(negedge clk); req_valid = 4'hF; #1;
        n_cmp++; if (req_ready !== 4'b0011) begin n_bad++; $display("FAIL rr_ptr_wrap: got %b want %b", req_ready, 4'b0011); end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_conflict();
        do_reset();
        req_valid = 4'b0011; set_req(0, 3'd3, 16'h1234); set_req(1, 3'd3, 16'h5678);
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL conf_ready0: got %b want %b", req_ready, 4'b0001); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, we2, conflict_cnt} !== {1'b1, 3'd3, 16'h1234, 1'b0, 16'd1})
            begin n_bad++; $display("FAIL conf_ports0: got %b %0d %h %b cnt=%0d want 1 3 1234 0 cnt=1", we1, write_addr1, write_data1, we2, conflict_cnt); end
        @(negedge clk); req_valid = 4'b0010; #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL conf_ready1: got %b want %b", req_ready, 4'b0010); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, we2, conflict_cnt} !== {1'b1, 3'd3, 16'h5678, 1'b0, 16'd1})
            begin n_bad++; $display("FAIL conf_ports1: got %b %0d %h %b cnt=%0d want 1 3 5678 0 cnt=1", we1, write_addr1, write_data1, we2, conflict_cnt); end
        @(negedge clk); req_valid = '0;
        @(posedge clk); #1;
        n_cmp++; if (rf[3] !== 16'h5678) begin n_bad++; $display("FAIL conf_rf_r3: got %h want 5678", rf[3]); end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b0001; set_req(0, 3'd1, 16'h0101);
        @(negedge clk);
        req_valid = 4'hF; set_all_distinct(); stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL stall_ready c%0d: got %b want 0000", c, req_ready); end
            @(posedge clk); #1;
            n_cmp++; if ({we1, we2} !== 2'b00) begin n_bad++; $display("FAIL stall_ports c%0d: got %b%b want 00", c, we1, we2); end
            @(negedge clk);
        end
        stall = 1'b0; #1;
        n_cmp++; if (req_ready !== 4'b0110) begin n_bad++; $display("FAIL stall_resume_ready: got %b want %b", req_ready, 4'b0110); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, we2, write_addr2} !== {1'b1, 3'd2, 1'b1, 3'd3})
            begin n_bad++; $display("FAIL stall_resume_ports: got %b %0d %b %0d want 1 2 1 3", we1, write_addr1, we2, write_addr2); end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        req_valid = 4'b0110; set_req(1, 3'd2, 16'h2121); set_req(2, 3'd2, 16'h2222);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL midop_ready0: got %b want %b", req_ready, 4'b0010); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, conflict_cnt} !== {1'b1, 3'd2, 16'h2121, 16'd1})
            begin n_bad++; $display("FAIL midop_ports0: got %b %0d %h cnt=%0d want 1 2 2121 cnt=1", we1, write_addr1, write_data1, conflict_cnt); end
        @(negedge clk); req_valid = 4'b0100; rst = 1'b0; #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL midop_rst_ready: got %b want 0000", req_ready); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, we2, write_addr1, write_data1, write_addr2, write_data2, conflict_cnt} !== '0)
            begin n_bad++; $display("FAIL midop_rst_ports: got %b %b %0d %h %0d %h cnt=%0d want all 0", we1, we2, write_addr1, write_data1, write_addr2, write_data2, conflict_cnt); end
        @(negedge clk); rst = 1'b1; #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL midop_release_ready: got %b want %b", req_ready, 4'b0100); end
        @(posedge clk); #1;
        n_cmp++; if ({we1, write_addr1, write_data1, we2} !== {1'b1, 3'd2, 16'h2222, 1'b0})
            begin n_bad++; $display("FAIL midop_release_ports: got %b %0d %h %b want 1 2 2222 0", we1, write_addr1, write_data1, we2); end
        @(negedge clk); req_valid = '0;
    endtask

    // Reference model state. It tracks the pointer, the counter and the expected register-file port values.
    int            m_ptr;
    logic [15:0]   m_cnt;
    logic          m_we1, m_we2;
    logic [AW-1:0] m_a1, m_a2;
    logic [DW-1:0] m_d1, m_d2;
    bit            pv [NREQ];
    logic [AW-1:0] pa [NREQ];
    logic [DW-1:0] pd [NREQ];

    // List valid requesters in round-robin order. A is the head of the list.
    // B is the first later entry whose address differs from A. Any same-address entry before B is deferred.
    task automatic model_select(output int a, output int b, output bit deferred);
        int order[$];
        a = -1; b = -1; deferred = 1'b0;
        for (int k = 0; k < NREQ; k++) if (pv[(m_ptr + k) % NREQ]) order.push_back((m_ptr + k) % NREQ);
        if (order.size() > 0) a = order[0];
        for (int j = 1; j < order.size(); j++) begin
            if (pa[order[j]] != pa[a]) begin b = order[j]; break; end
            deferred = 1'b1;
        end
    endtask

    task automatic test_random();
        int a, b;
        bit deferred;
        logic [NREQ-1:0] exp_ready;
        do_reset();
        m_ptr = 0; m_cnt = '0; m_we1 = 0; m_we2 = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 2) == 0) begin
                    pv[i] = 1'b1; pa[i] = AW'($urandom_range(0, 7)); pd[i] = DW'($urandom);
                end
                req_valid[i] = pv[i];
                set_req(i, pa[i], pd[i]);
            end
            stall = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 63) != 0);
            #1;
            model_select(a, b, deferred);
            exp_ready = '0;
            if (rst && !stall) begin
                if (a >= 0) exp_ready[a] = 1'b1;
                if (b >= 0) exp_ready[b] = 1'b1;
            end
            n_cmp++; if (req_ready !== exp_ready) begin n_bad++; $display("FAIL rand_ready cyc%0d: got %b want %b", cyc, req_ready, exp_ready); end
            if (!rst) begin
                m_ptr = 0; m_cnt = '0; m_we1 = 0; m_we2 = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0;
            end else if (stall) begin
                m_we1 = 0; m_we2 = 0;
            end else begin
                m_we1 = (a >= 0); m_we2 = (b >= 0);
                if (a >= 0) begin m_a1 = pa[a]; m_d1 = pd[a]; pv[a] = 1'b0; m_ptr = (a + 1) % NREQ; end
                if (b >= 0) begin m_a2 = pa[b]; m_d2 = pd[b]; pv[b] = 1'b0; m_ptr = (b + 1) % NREQ; end
                if (deferred && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
            @(posedge clk); #1;
            n_cmp++; if ({we1, write_addr1, write_data1, we2, write_addr2, write_data2, conflict_cnt} !== {m_we1, m_a1, m_d1, m_we2, m_a2, m_d2, m_cnt})
                begin n_bad++; $display("FAIL rand_ports cyc%0d: got %b %0d %h %b %0d %h cnt=%0d want %b %0d %h %b %0d %h cnt=%0d", cyc,
                    we1, write_addr1, write_data1, we2, write_addr2, write_data2, conflict_cnt, m_we1, m_a1, m_d1, m_we2, m_a2, m_d2, m_cnt); end
            n_cmp++; if (we1 && we2 && write_addr1 == write_addr2) begin n_bad++; $display("FAIL rand_same_addr cyc%0d: got addr %0d on both ports want distinct", cyc, write_addr1); end
        end
        @(negedge clk); req_valid = '0; stall = 1'b0; rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_single_write();
        test_round_robin();
        test_conflict();
        test_stall();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
